// File: rtl/pll_lock_supervisor.sv
// PLL lock supervisor: pulses the PLL reset, waits for a synchronized lock,
// qualifies it for a stability window, retries on timeout, latches a fault.
module pll_lock_supervisor #(
    parameter int unsigned RST_PULSE_CYC    = 50,
    parameter int unsigned LOCK_TIMEOUT_CYC = 50000,
    parameter int unsigned STABLE_CYC       = 1024,
    parameter int unsigned MAX_RETRY        = 8
) (
    input  logic       refclk,
    input  logic       rst,
    input  logic       pll_locked,
    output logic       pll_rst,
    output logic       sys_rst,
    output logic       ready,
    output logic       fault,
    output logic [3:0] retry_count
);

    localparam int unsigned MAX_AB  = (RST_PULSE_CYC > LOCK_TIMEOUT_CYC) ? RST_PULSE_CYC : LOCK_TIMEOUT_CYC;
    localparam int unsigned CNT_MAX = (MAX_AB > STABLE_CYC) ? MAX_AB : STABLE_CYC;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

    typedef enum logic [2:0] {
        S_PLL_RST   = 3'd0,
        S_WAIT_LOCK = 3'd1,
        S_STABLE    = 3'd2,
        S_RUN       = 3'd3,
        S_FAULT     = 3'd4
    } state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [3:0]         retry_q, retry_d;
    logic               sync1_q, sync1_d;
    logic               sync2_q, sync2_d;
    logic               pll_rst_q, pll_rst_d;
    logic               sys_rst_q, sys_rst_d;
    logic               ready_q, ready_d;
    logic               fault_q, fault_d;

    logic               locked_s;
    logic [3:0]         retry_inc;

    // Two-flop synchronizer for the asynchronous lock indicator
    always_comb begin
        sync1_d = pll_locked;
        sync2_d = sync1_q;
    end

    assign locked_s  = sync2_q;
    assign retry_inc = retry_q + 4'd1;

    // State, cycle counter and retry bookkeeping registers
    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            state_q <= S_PLL_RST;
            cnt_q   <= '0;
            retry_q <= 4'd0;
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            retry_q <= retry_d;
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
        end
    end

    // Next-state logic; the shared counter restarts on every state change
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + CNT_W'(1);
        retry_d = retry_q;
        unique case (state_q)
            S_PLL_RST: begin
                if (cnt_q == CNT_W'(RST_PULSE_CYC - 1)) state_d = S_WAIT_LOCK;
            end
            S_WAIT_LOCK: begin
                // A lock seen on the timeout cycle wins over the retry
                if (locked_s) begin
                    state_d = S_STABLE;
                end else if (cnt_q == CNT_W'(LOCK_TIMEOUT_CYC - 1)) begin
                    retry_d = retry_inc;
                    state_d = (retry_inc == 4'(MAX_RETRY)) ? S_FAULT : S_PLL_RST;
                end
            end
            S_STABLE: begin
                if (!locked_s) begin
                    state_d = S_WAIT_LOCK;
                end else if (cnt_q == CNT_W'(STABLE_CYC - 1)) begin
                    state_d = S_RUN;
                    retry_d = 4'd0;
                end
            end
            S_RUN: begin
                cnt_d = cnt_q;
                if (!locked_s) begin
                    state_d = S_PLL_RST;
                    retry_d = 4'd0;
                end
            end
            S_FAULT: begin
                cnt_d = cnt_q;
            end
            default: begin
                state_d = S_PLL_RST;
            end
        endcase
        if (state_d != state_q) cnt_d = '0;
    end

    // Moore output decode of the state being entered, registered alongside it
    always_comb begin
        pll_rst_d = (state_d == S_PLL_RST) || (state_d == S_FAULT);
        sys_rst_d = (state_d != S_RUN);
        ready_d   = (state_d == S_RUN);
        fault_d   = (state_d == S_FAULT);
    end

    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            pll_rst_q <= 1'b1;
            sys_rst_q <= 1'b1;
            ready_q   <= 1'b0;
            fault_q   <= 1'b0;
        end else begin
            pll_rst_q <= pll_rst_d;
            sys_rst_q <= sys_rst_d;
            ready_q   <= ready_d;
            fault_q   <= fault_d;
        end
    end

    assign pll_rst     = pll_rst_q;
    assign sys_rst     = sys_rst_q;
    assign ready       = ready_q;
    assign fault       = fault_q;
    assign retry_count = retry_q;

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Bench for pll_lock_supervisor: directed scenarios with literal timing
// expectations, then randomized lock behaviour against a phase/countdown model.
module tb_pll_lock_supervisor;

    localparam int RP = 4;
    localparam int TO = 20;
    localparam int SC = 8;
    localparam int MR = 3;

    logic       refclk = 1'b0;
    logic       rst;
    logic       pll_locked;
    logic       pll_rst;
    logic       sys_rst;
    logic       ready;
    logic       fault;
    logic [3:0] retry_count;

    int checks = 0;
    int errors = 0;

    pll_lock_supervisor #(
        .RST_PULSE_CYC   (RP),
        .LOCK_TIMEOUT_CYC(TO),
        .STABLE_CYC      (SC),
        .MAX_RETRY       (MR)
    ) dut (
        .refclk     (refclk),
        .rst        (rst),
        .pll_locked (pll_locked),
        .pll_rst    (pll_rst),
        .sys_rst    (sys_rst),
        .ready      (ready),
        .fault      (fault),
        .retry_count(retry_count)
    );

    always #5 refclk = ~refclk;

    // Model: phase plus cycles-left countdown; lock is seen two edges late
    localparam int P_PULSE = 0, P_WAIT = 1, P_SETTLE = 2, P_UP = 3, P_DEAD = 4;
    int m_phase = P_PULSE;
    int m_left  = RP;
    int m_retry = 0;
    bit m_hist1 = 1'b0;
    bit m_hist2 = 1'b0;
    bit m_seen;

    always @(posedge refclk or posedge rst) begin
        if (rst) begin
            m_phase = P_PULSE; m_left = RP; m_retry = 0;
            m_hist1 = 1'b0;    m_hist2 = 1'b0;
        end else begin
            m_seen  = m_hist2;
            m_hist2 = m_hist1;
            m_hist1 = pll_locked;
            case (m_phase)
                P_PULSE: begin
                    m_left = m_left - 1;
                    if (m_left == 0) begin m_phase = P_WAIT; m_left = TO; end
                end
                P_WAIT: begin
                    if (m_seen) begin
                        m_phase = P_SETTLE; m_left = SC;
                    end else begin
                        m_left = m_left - 1;
                        if (m_left == 0) begin
                            m_retry = m_retry + 1;
                            if (m_retry == MR) m_phase = P_DEAD;
                            else begin m_phase = P_PULSE; m_left = RP; end
                        end
                    end
                end
                P_SETTLE: begin
                    if (!m_seen) begin
                        m_phase = P_WAIT; m_left = TO;
                    end else begin
                        m_left = m_left - 1;
                        if (m_left == 0) begin m_phase = P_UP; m_retry = 0; end
                    end
                end
                P_UP: begin
                    if (!m_seen) begin m_phase = P_PULSE; m_left = RP; m_retry = 0; end
                end
                default: ;
            endcase
        end
    end

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
        end
    endtask

    // One clock: compare DUT against the model at negedge, return at posedge+2
    task automatic cycle();
        logic e_pr, e_sr, e_rd, e_ft;
        @(negedge refclk);
        e_pr = (m_phase == P_PULSE) || (m_phase == P_DEAD);
        e_sr = (m_phase != P_UP);
        e_rd = (m_phase == P_UP);
        e_ft = (m_phase == P_DEAD);
        checks++;
        if (pll_rst !== e_pr || sys_rst !== e_sr || ready !== e_rd ||
            fault !== e_ft || retry_count !== 4'(m_retry)) begin
            errors++;
            $display("FAIL model_cmp t=%0t: pll_rst=%b/%b sys_rst=%b/%b ready=%b/%b fault=%b/%b retry=%0d/%0d (got/exp)",
                     $time, pll_rst, e_pr, sys_rst, e_sr, ready, e_rd, fault, e_ft, retry_count, m_retry);
        end
        @(posedge refclk);
        #2;
    endtask

    function automatic logic sig(input int sel);
        case (sel)
            0: return pll_rst;
            1: return sys_rst;
            2: return ready;
            default: return fault;
        endcase
    endfunction

    task automatic count_until(input int sel, input logic val, input int bound, output int n);
        n = 0;
        while (sig(sel) !== val && n < bound) begin
            cycle();
            n++;
        end
    endtask

    task automatic restart();
        rst = 1'b1;
        cycle();
        rst = 1'b0;
    endtask

    initial begin
        int n, n2, run;
        rst = 1'b1;
        pll_locked = 1'b0;
        repeat (3) cycle();
        chk("rst_pll_rst", int'(pll_rst), 1);
        chk("rst_sys_rst", int'(sys_rst), 1);
        chk("rst_ready", int'(ready), 0);
        chk("rst_fault", int'(fault), 0);
        chk("rst_retry", int'(retry_count), 0);

        // Normal lock
        rst = 1'b0;
        count_until(0, 1'b0, 50, n);
        chk("pulse_len", n, 4);
        repeat (5) cycle();
        pll_locked = 1'b1;
        cycle();
        count_until(1, 1'b0, 50, n);
        chk("lock_to_run", n, 10);
        chk("run_ready", int'(ready), 1);
        chk("run_retry", int'(retry_count), 0);

        // Loss of lock in RUN, then relock
        repeat (3) cycle();
        pll_locked = 1'b0;
        cycle();
        count_until(1, 1'b1, 20, n);
        chk("loss_to_sysrst", n, 2);
        chk("loss_ready", int'(ready), 0);
        count_until(0, 1'b0, 20, n);
        chk("loss_pulse_len", n, 4);
        chk("loss_retry", int'(retry_count), 0);
        pll_locked = 1'b1;
        count_until(2, 1'b1, 60, n);
        chk("relock_ready", int'(ready), 1);

        // Glitch during STABLE
        pll_locked = 1'b0;
        restart();
        count_until(0, 1'b0, 50, n);
        repeat (2) cycle();
        pll_locked = 1'b1;
        cycle();
        repeat (4) cycle();
        pll_locked = 1'b0;
        cycle();
        pll_locked = 1'b1;
        count_until(1, 1'b0, 60, n2);
        chk("glitch_to_run", 5 + n2, 16);
        chk("glitch_retry", int'(retry_count), 0);

        // Timeout boundary: lock decided exactly on the last wait cycle
        pll_locked = 1'b0;
        restart();
        count_until(0, 1'b0, 50, n);
        repeat (17) cycle();
        pll_locked = 1'b1;
        repeat (3) cycle();
        chk("bound_pll_rst", int'(pll_rst), 0);
        chk("bound_sys_rst", int'(sys_rst), 1);
        chk("bound_retry", int'(retry_count), 0);

        // One cycle too late: the timeout fires first
        pll_locked = 1'b0;
        restart();
        count_until(0, 1'b0, 50, n);
        repeat (18) cycle();
        pll_locked = 1'b1;
        repeat (3) cycle();
        chk("late_pll_rst", int'(pll_rst), 1);
        chk("late_retry", int'(retry_count), 1);

        // Repeated timeouts into FAULT
        pll_locked = 1'b0;
        restart();
        count_until(3, 1'b1, 200, n);
        chk("edges_to_fault", n, 72);
        chk("fault_pll_rst", int'(pll_rst), 1);
        chk("fault_sys_rst", int'(sys_rst), 1);
        chk("fault_retry", int'(retry_count), 3);
        pll_locked = 1'b1;
        repeat (30) cycle();
        chk("fault_sticky", int'(fault), 1);
        chk("fault_no_ready", int'(ready), 0);

        // Asynchronous reset mid-cycle from FAULT
        #1 rst = 1'b1;
        #1;
        chk("async_pll_rst", int'(pll_rst), 1);
        chk("async_sys_rst", int'(sys_rst), 1);
        chk("async_ready", int'(ready), 0);
        chk("async_fault", int'(fault), 0);
        chk("async_retry", int'(retry_count), 0);
        cycle();
        rst = 1'b0;
        count_until(0, 1'b0, 50, n);
        chk("async_pulse_len", n, 4);

        // Randomized lock behaviour with occasional resets
        run = 0;
        for (int i = 0; i < 4000; i++) begin
            if (run == 0) begin
                pll_locked = ~pll_locked;
                run = pll_locked ? int'($urandom_range(1, 40)) : int'($urandom_range(1, 30));
            end
            run--;
            rst = ($urandom_range(0, 299) == 0);
            cycle();
        end
        rst = 1'b0;
        cycle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pll_lock_supervisor.md
PLL_LOCK_SUPERVISOR -- requirements
Module: pll_lock_supervisor

Interface
REQ-001 SHALL have parameter RST_PULSE_CYC, default 50, meaning refclk cycles pll_rst is held high per attempt (1 us at 50 MHz).
REQ-002 SHALL have parameter LOCK_TIMEOUT_CYC, default 50000, meaning refclk cycles allowed for lock per attempt (1 ms).
REQ-003 SHALL have parameter STABLE_CYC, default 1024, meaning consecutive synchronized-locked cycles required before release.
REQ-004 SHALL have parameter MAX_RETRY, default 8, range 1..15, meaning failed lock attempts before fault.
REQ-005 SHALL have port refclk  input  1  free-running 50.0 MHz reference clock; the only clock.
REQ-006 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-007 SHALL have port pll_locked  input  1  PLL lock indicator, asynchronous to refclk.
REQ-008 SHALL have port pll_rst  output  1  active-high reset to the PLL.
REQ-009 SHALL have port sys_rst  output  1  active-high reset for logic clocked by the PLL output clock.
REQ-010 SHALL have port ready  output  1  high while lock is established and stable.
REQ-011 SHALL have port fault  output  1  sticky lock-failure flag.
REQ-012 SHALL have port retry_count  output  4  failed attempts in the current acquisition.

Function
REQ-013 SHALL synchronize pll_locked through two refclk flops into locked_s; all decisions use locked_s only.
REQ-014 SHALL implement states PLL_RST, WAIT_LOCK, STABLE, RUN, FAULT with one shared cycle counter, cleared on every state entry and sized for the largest parameter.
REQ-015 SHALL drive all outputs as Moore decodes of registered state: pll_rst=1 in PLL_RST and FAULT; sys_rst=1 in every state except RUN; ready=1 only in RUN; fault=1 only in FAULT.
REQ-016 PLL_RST: SHALL hold for exactly RST_PULSE_CYC cycles, then go to WAIT_LOCK.
REQ-017 WAIT_LOCK: locked_s=1 SHALL go to STABLE; otherwise after LOCK_TIMEOUT_CYC cycles SHALL increment retry_count and go to PLL_RST, or go to FAULT if the incremented value equals MAX_RETRY.
REQ-018 WAIT_LOCK: locked_s rising on the timeout cycle SHALL take priority (go to STABLE, no increment).
REQ-019 STABLE: locked_s=1 for STABLE_CYC consecutive cycles SHALL go to RUN; any locked_s=0 SHALL return to WAIT_LOCK with a fresh timeout and no retry increment.
REQ-020 RUN: locked_s=0 SHALL go to PLL_RST and clear retry_count to 0 (new acquisition); sys_rst reasserts on that same edge.
REQ-021 retry_count SHALL clear to 0 on entry to RUN and SHALL never exceed MAX_RETRY.
REQ-022 FAULT SHALL be absorbing; only rst exits it; pll_locked is ignored there.
REQ-023 Timing: with first edge sampling pll_locked=1 at edge t in WAIT_LOCK and stable lock, state SHALL enter STABLE at t+2 and RUN (sys_rst=0) at t+2+STABLE_CYC.

Reset
REQ-024 rst=1 SHALL immediately force state=PLL_RST, counter=0, sync flops=0, retry_count=0, pll_rst=1, sys_rst=1, ready=0, fault=0.
REQ-025 After rst falls, the first PLL_RST pulse SHALL last exactly RST_PULSE_CYC cycles.
REQ-026 rst asserted mid-operation (any state, incl. FAULT) SHALL behave identically to power-on reset.

Verification (RST_PULSE_CYC=4, LOCK_TIMEOUT_CYC=20, STABLE_CYC=8, MAX_RETRY=3)
REQ-027 Normal lock: rst release, pll_locked=1 five cycles after pll_rst falls -> pll_rst high 4 cycles; sys_rst falls 10 edges after pll_locked first sampled; ready=1, retry_count=0.
REQ-028 Timeouts to fault: pll_locked held 0 -> three 4-cycle pll_rst pulses separated by 20-cycle waits, retry_count 1,2, then FAULT: fault=1, pll_rst=1, sys_rst=1; later pll_locked=1 has no effect.
REQ-029 Glitch in STABLE: pll_locked high 5 cycles, low 1, then high -> return to WAIT_LOCK, no retry increment; RUN only after 8 further consecutive locked cycles.
REQ-030 Loss of lock in RUN: pll_locked drops -> sys_rst=1 and ready=0 two edges later, 4-cycle pll_rst pulse, retry_count=0, relock reaches RUN.
REQ-031 Timeout boundary: pll_locked sampled high exactly on the 20th WAIT_LOCK cycle -> STABLE, retry_count unchanged.
REQ-032 Async reset from FAULT: pulse rst mid-cycle -> all outputs at REQ-024 values before the next refclk edge; normal sequence restarts.
